// File: rtl/core_run_monitor.sv
// Run controller/checker around the RV32IM core: reset stretch, cycle and retire
// counters, write-back checking against an expected queue, halt/watchdog end detection.
// Optional: define MON_XCHECK_EN to treat an X/Z instruction in RUN as a halt (simulation only).
module core_run_monitor #(
    parameter int              XLEN       = 32,
    parameter int              RST_CYCLES = 4,
    parameter int              TIMEOUT    = 1024,
    parameter int              EXP_DEPTH  = 16,
    parameter int              CNT_W      = 16,
    parameter logic [XLEN-1:0] HALT_INSTR = XLEN'(32'h00000073)
) (
    input  logic             clk,
    input  logic             rst,
    output logic             core_rst,
    input  logic [XLEN-1:0]  instruction,
    input  logic [XLEN-1:0]  result,
    input  logic             wb_valid,
    input  logic             exp_wr_en,
    input  logic [XLEN-1:0]  exp_wr_data,
    output logic             exp_full,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] retired_cnt,
    output logic             done,
    output logic             pass,
    output logic [1:0]       fail_code,
    output logic [XLEN-1:0]  mismatch_data
);

    // state   | meaning
    // ST_HOLD | core held in reset while the stretch timer runs down
    // ST_RUN  | core released; counting, checking write-backs, watching for end
    // ST_END  | run finished; results frozen until rst
    typedef enum logic [1:0] {ST_HOLD, ST_RUN, ST_END} state_t;

    localparam int AW = $clog2(EXP_DEPTH);
    localparam int PW = AW + 1;
    localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [HW-1:0] HOLD_INIT = HW'(RST_CYCLES - 1);
    localparam logic [WW-1:0] WD_INIT   = WW'(TIMEOUT - 1);

    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;
    localparam logic [1:0] FC_QUEUE    = 2'd3;

    state_t          state, state_nxt;
    logic [HW-1:0]   hold_cnt;
    logic [WW-1:0]   wd_cnt;
    logic [XLEN-1:0] q_mem [EXP_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr, q_count, q_left;
    logic [XLEN-1:0] q_head;
    logic            run, q_empty, q_full, pop, push;
    logic            hold_tc, wd_tc, halt;
    logic            mm_seen, mm_seen_nxt;
    logic [1:0]      fail_nxt;
    logic [XLEN-1:0] mm_nxt;

    assign run     = (state == ST_RUN);
    assign q_count = wr_ptr - rd_ptr;
    assign q_empty = (q_count == '0);
    assign q_full  = (q_count == PW'(EXP_DEPTH));
    assign q_head  = q_mem[rd_ptr[AW-1:0]];
    assign pop     = run && wb_valid && !q_empty;
    // A pop in the same cycle frees the slot, so a push into a full queue still lands.
    assign push    = exp_wr_en && (!q_full || pop);
    assign q_left  = q_count - PW'(pop);
    assign hold_tc = (hold_cnt == '0);
    assign wd_tc   = (wd_cnt == '0);

`ifdef MON_XCHECK_EN
    assign halt = (instruction == HALT_INSTR) || ((^instruction) === 1'bx);
`else
    assign halt = (instruction == HALT_INSTR);
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= ST_HOLD;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_HOLD: if (hold_tc) state_nxt = ST_RUN;
            ST_RUN:  if (halt || wd_tc) state_nxt = ST_END;
            ST_END:  state_nxt = ST_END;
            default: state_nxt = ST_HOLD;
        endcase
    end

    always_comb begin
        core_rst = (state != ST_HOLD);
        done     = (state == ST_END);
        pass     = (state == ST_END) && (fail_code == FC_NONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= HOLD_INIT;
            wd_cnt   <= WD_INIT;
        end else begin
            if (state == ST_HOLD && !hold_tc) hold_cnt <= hold_cnt - HW'(1);
            if (run && !wd_tc)                wd_cnt   <= wd_cnt - WW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt   <= '0;
            retired_cnt <= '0;
        end else if (run) begin
            if (cycle_cnt != '1)                cycle_cnt   <= cycle_cnt + CNT_W'(1);
            if (wb_valid && retired_cnt != '1)  retired_cnt <= retired_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) q_mem[wr_ptr[AW-1:0]] <= exp_wr_data;
    end

    assign exp_full = q_full;

    // The first error code sticks; mismatch_data always keeps the first bad result.
    always_comb begin
        fail_nxt    = fail_code;
        mm_nxt      = mismatch_data;
        mm_seen_nxt = mm_seen;
        if (run && wb_valid) begin
            if (q_empty) begin
                if (fail_nxt == FC_NONE) fail_nxt = FC_QUEUE;
            end else if (result != q_head) begin
                if (!mm_seen) begin
                    mm_seen_nxt = 1'b1;
                    mm_nxt      = result;
                end
                if (fail_nxt == FC_NONE) fail_nxt = FC_MISMATCH;
            end
        end
        if (run) begin
            if (halt) begin
                if (fail_nxt == FC_NONE && q_left != '0) fail_nxt = FC_QUEUE;
            end else if (wd_tc) begin
                if (fail_nxt == FC_NONE) fail_nxt = FC_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fail_code     <= FC_NONE;
            mismatch_data <= '0;
            mm_seen       <= 1'b0;
        end else begin
            fail_code     <= fail_nxt;
            mismatch_data <= mm_nxt;
            mm_seen       <= mm_seen_nxt;
        end
    end

endmodule

// File: tb/tb_core_run_monitor.sv
// Bench for core_run_monitor: directed scenarios plus randomized runs, each cycle
// compared against a queue-based behavioural model of the run rules.
module tb_core_run_monitor;

    localparam int          XLEN       = 32;
    localparam int          RST_CYCLES = 4;
    localparam int          TIMEOUT    = 20;
    localparam int          EXP_DEPTH  = 8;
    localparam int          CNT_W      = 4;
    localparam int          CMAX       = 15;
    localparam logic [31:0] HALT       = 32'h00000073;
    localparam logic [31:0] NOP        = 32'h00000013;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             core_rst;
    logic [XLEN-1:0]  instruction = NOP;
    logic [XLEN-1:0]  result = '0;
    logic             wb_valid = 1'b0;
    logic             exp_wr_en = 1'b0;
    logic [XLEN-1:0]  exp_wr_data = '0;
    logic             exp_full;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retired_cnt;
    logic             done;
    logic             pass;
    logic [1:0]       fail_code;
    logic [XLEN-1:0]  mismatch_data;

    int n_checks = 0;
    int n_errors = 0;

    // model: phase 0 = core held, 1 = running, 2 = finished
    int          m_phase, m_hold, m_runs, m_cyc, m_ret, m_fail;
    logic [31:0] m_mm;
    bit          m_mmseen;
    logic [31:0] mq[$];

    core_run_monitor #(
        .XLEN(XLEN), .RST_CYCLES(RST_CYCLES), .TIMEOUT(TIMEOUT),
        .EXP_DEPTH(EXP_DEPTH), .CNT_W(CNT_W), .HALT_INSTR(HALT)
    ) dut (
        .clk(clk), .rst(rst), .core_rst(core_rst), .instruction(instruction),
        .result(result), .wb_valid(wb_valid), .exp_wr_en(exp_wr_en),
        .exp_wr_data(exp_wr_data), .exp_full(exp_full), .cycle_cnt(cycle_cnt),
        .retired_cnt(retired_cnt), .done(done), .pass(pass), .fail_code(fail_code),
        .mismatch_data(mismatch_data)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL sim_time_limit: got running expected finished");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_hold = 0; m_runs = 0; m_cyc = 0; m_ret = 0; m_fail = 0;
        m_mm = '0; m_mmseen = 0;
        mq.delete();
    endtask

    task automatic model_step(input logic [31:0] ins, input logic [31:0] res, input bit wbv,
                              input bit wren, input logic [31:0] wd);
        logic [31:0] e;
        if (m_phase == 1) begin
            m_runs++;
            if (m_cyc < CMAX) m_cyc++;
            if (wbv) begin
                if (m_ret < CMAX) m_ret++;
                if (mq.size() == 0) begin
                    if (m_fail == 0) m_fail = 3;
                end else begin
                    e = mq.pop_front();
                    if (e != res) begin
                        if (!m_mmseen) begin m_mmseen = 1; m_mm = res; end
                        if (m_fail == 0) m_fail = 1;
                    end
                end
            end
            if (ins == HALT) begin
                if (m_fail == 0 && mq.size() != 0) m_fail = 3;
                m_phase = 2;
            end else if (m_runs == TIMEOUT) begin
                if (m_fail == 0) m_fail = 2;
                m_phase = 2;
            end
        end else if (m_phase == 0) begin
            m_hold++;
            if (m_hold == RST_CYCLES) m_phase = 1;
        end
        if (wren && mq.size() < EXP_DEPTH) mq.push_back(wd);
    endtask

    task automatic compare_all();
        check_val("core_rst",      32'(core_rst),      32'(m_phase != 0));
        check_val("done",          32'(done),          32'(m_phase == 2));
        check_val("pass",          32'(pass),          32'(m_phase == 2 && m_fail == 0));
        check_val("fail_code",     32'(fail_code),     32'(m_fail));
        check_val("cycle_cnt",     32'(cycle_cnt),     32'(m_cyc));
        check_val("retired_cnt",   32'(retired_cnt),   32'(m_ret));
        check_val("exp_full",      32'(exp_full),      32'(mq.size() == EXP_DEPTH));
        check_val("mismatch_data", mismatch_data,      m_mm);
    endtask

    // Called at a falling edge: drive, let one rising edge pass, then compare.
    task automatic cyc(input logic [31:0] ins, input logic [31:0] res, input bit wbv,
                       input bit wren, input logic [31:0] wd);
        instruction = ins; result = res; wb_valid = wbv; exp_wr_en = wren; exp_wr_data = wd;
        @(posedge clk);
        model_step(ins, res, wbv, wren, wd);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1'b0;
        instruction = NOP; result = '0; wb_valid = 0; exp_wr_en = 0; exp_wr_data = '0;
        model_reset();
        #1;
        compare_all();
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic push_hold(input logic [31:0] a, input logic [31:0] b);
        cyc(NOP, 0, 0, 1, a);
        cyc(NOP, 0, 0, 1, b);
        cyc(NOP, 0, 0, 0, 0);
        cyc(NOP, 0, 0, 0, 0);
    endtask

    initial begin
        int n;
        logic [31:0] pv [6];
        logic [31:0] r;
        pv[0] = 32'd10; pv[1] = 32'd18; pv[2] = 32'd10;
        pv[3] = 32'd20; pv[4] = 32'd30; pv[5] = 32'd28;

        // reset values, reset stretch, then a clean passing program
        do_reset();
        check_val("rst_done", 32'(done), 32'd0);
        check_val("rst_core_rst", 32'(core_rst), 32'd0);
        n = 0;
        while (!core_rst && n < 10) begin
            cyc(NOP, 0, 0, 0, 0);
            n++;
        end
        check_val("rst_stretch", 32'(n), 32'd4);
        for (int i = 0; i < 6; i++) cyc(NOP, 0, 0, 1, pv[i]);
        for (int i = 0; i < 6; i++) cyc(NOP, pv[i], 1, 0, 0);
        cyc(HALT, 0, 0, 0, 0);
        check_val("pass_done", 32'(done), 32'd1);
        check_val("pass_pass", 32'(pass), 32'd1);
        check_val("pass_retired", 32'(retired_cnt), 32'd6);
        check_val("pass_fail", 32'(fail_code), 32'd0);
        cyc(NOP, 32'd99, 1, 1, 32'd5);
        check_val("end_frozen_ret", 32'(retired_cnt), 32'd6);

        // first mismatch latched, later match does not clear it
        do_reset();
        push_hold(32'd28, 32'd5);
        cyc(NOP, 32'd27, 1, 0, 0);
        cyc(NOP, 0, 0, 0, 0);
        cyc(NOP, 32'd5, 1, 0, 0);
        cyc(HALT, 0, 0, 0, 0);
        check_val("mm_fail", 32'(fail_code), 32'd1);
        check_val("mm_data", mismatch_data, 32'd27);
        check_val("mm_pass", 32'(pass), 32'd0);

        // watchdog: done after exactly TIMEOUT run cycles, cycle_cnt saturated
        do_reset();
        for (int i = 0; i < RST_CYCLES; i++) cyc(NOP, 0, 0, 0, 0);
        n = 0;
        while (!done && n < 40) begin
            cyc(NOP, 0, 0, 0, 0);
            n++;
        end
        check_val("to_cycles", 32'(n), 32'd20);
        check_val("to_fail", 32'(fail_code), 32'd2);
        check_val("to_cycle_sat", 32'(cycle_cnt), 32'd15);

        // leftover expected entry at halt
        do_reset();
        push_hold(32'd1, 32'd2);
        cyc(NOP, 32'd1, 1, 0, 0);
        cyc(HALT, 0, 0, 0, 0);
        check_val("left_fail", 32'(fail_code), 32'd3);

        // underflow, then push+pop on empty
        do_reset();
        for (int i = 0; i < RST_CYCLES; i++) cyc(NOP, 0, 0, 0, 0);
        cyc(NOP, 32'd0, 1, 0, 0);
        check_val("uf_fail", 32'(fail_code), 32'd3);
        cyc(NOP, 32'd4, 1, 1, 32'd7);
        cyc(NOP, 32'd7, 1, 0, 0);
        cyc(HALT, 0, 0, 0, 0);
        check_val("uf_final", 32'(fail_code), 32'd3);

        // queue full: drop when full, push+pop when full accepted
        do_reset();
        for (int i = 0; i < 9; i++) cyc(NOP, 0, 0, 1, 32'(100 + i));
        check_val("full_flag", 32'(exp_full), 32'd1);
        cyc(NOP, 32'd100, 1, 1, 32'd200);
        check_val("full_swap", 32'(exp_full), 32'd1);
        for (int i = 1; i < 8; i++) cyc(NOP, 32'(100 + i), 1, 0, 0);
        cyc(NOP, 32'd200, 1, 0, 0);
        cyc(HALT, 0, 0, 0, 0);
        check_val("full_pass", 32'(pass), 32'd1);

        // randomized runs, occasionally reset mid-run
        for (int run_i = 0; run_i < 25; run_i++) begin
            do_reset();
            for (int c = 0; c < 40; c++) begin
                if ($urandom_range(0, 59) == 0) begin
                    do_reset();
                end else begin
                    logic [31:0] ins;
                    bit wbv, wren;
                    ins = ($urandom_range(0, 24) == 0) ? HALT : $urandom;
                    if (ins == HALT && $urandom_range(0, 1) == 0) ins = NOP;
                    wbv  = $urandom_range(0, 1) == 1;
                    wren = $urandom_range(0, 9) < 4;
                    r = (mq.size() > 0 && $urandom_range(0, 7) != 0) ? mq[0] : 32'($urandom_range(0, 15));
                    cyc(ins, r, wbv, wren, 32'($urandom_range(0, 15)));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
